bus_grant_sequencer: RTL and testbench
======================================

Name: bus_grant_sequencer

Overview:
- Upstream stage of the datapath's 32-to-5 bus-source encoder.
- Accepts a 32-bit mask of bus sources that the control unit wants driven in sequence.
- Emits one registered one-hot grant at a time, highest bit first, matching the encoder's priority. The encoder only ever sees a single set bit.
- The consumer (bus/register-load logic) acknowledges each grant. A done pulse marks the end of the job.

Parameters:
- N, 32, number of bus sources. Fixed at 32 to match the downstream encoder width.
- CW, 6, width of grant_count (holds 0..32).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous, active-low reset.
- req_valid  in  1  new job offered.
- req_ready  out  1  sequencer can accept a job.
- req_mask  in  32  sources to grant. Bit 31 is highest priority.
- grant  out  32  one-hot bus-source select to the encoder. 0 when no grant.
- grant_valid  out  1  grant is meaningful.
- grant_ack  in  1  consumer used the current grant this cycle.
- flush  in  1  abort the current job.
- done  out  1  one-cycle pulse: job completed normally.
- busy  out  1  a job is in progress (state != IDLE).
- grant_count  out  CW  acks taken in the current or last job.

Behaviour:
Reset:
- While clear==0 at a rising edge, the next state is IDLE and pending=0.
- All outputs are 0: grant=0, grant_valid=0, done=0, busy=0, grant_count=0.
- req_ready is forced to 0 while clear is low, regardless of state.

States: IDLE, GRANT, DONE.

IDLE:
- req_ready=1. Job accepted at an edge where req_valid&req_ready=1.
- On accept: pending<=req_mask and grant_count<=0.
  - If req_mask!=0: grant<=highest set bit of req_mask, grant_valid<=1, go to GRANT.
  - If req_mask==0: go to DONE. No grant is ever issued.

GRANT:
- req_ready=0. req_valid is ignored, with no side effects.
- grant and grant_valid stay stable until grant_ack is sampled high.
- On ack:
  - clear the granted bit from pending; grant_count<=grant_count+1.
  - If the remaining pending!=0: grant<=highest remaining bit, visible the next cycle. With ack held high, one grant per cycle.
  - If the remaining pending==0: grant<=0, grant_valid<=0, go to DONE.

DONE:
- done=1 for exactly one cycle; grant=0, grant_valid=0.
- Unconditionally go to IDLE at the next edge.

flush:
- Sampled in GRANT or DONE. At the next edge: pending<=0, grant<=0, grant_valid<=0, go to IDLE.
- No done pulse. grant_count holds its value.
- flush and grant_ack in the same cycle: flush wins and the ack is not counted.
- flush in IDLE: no effect; a simultaneous req_valid is still accepted.

Invariants:
- grant is always 0 or one-hot.
- grant_valid==(grant!=0).
- A granted bit is never granted twice in one job.
- grant_count never exceeds 32.

Latency:
- Accept at edge k → first grant valid after edge k.
- Job with m bits and continuous ack: done is high in cycle k+m, req_ready is high again in cycle k+m+1.

Test Plan:
- Reset: hold clear=0 for 2 cycles with req_valid=1, req_mask=0xFFFFFFFF → req_ready=0, grant=0, busy=0, done=0. Release clear → req_ready=1 next cycle and no job has been taken.
- Continuous ack: mask 0x80000001, grant_ack=1 always → grant=0x80000000, then 0x00000001 on consecutive cycles. done=1 the following cycle with grant_count=2. req_ready=1 one cycle after done.
- Stalled ack: mask 0x00000050, ack low for 3 cycles → grant stays 0x00000040 for 3+ cycles. Then ack → 0x00000010, then done after its ack; grant_count=2.
- Empty job: mask 0x00000000 → no grant_valid ever; done pulses the cycle after accept; grant_count=0.
- Flush mid-job: mask 0xFFFFFFFF, 5 acks (grants 0x80000000…0x08000000). On the 6th ack assert flush as well → next cycle IDLE, grant=0, no done, grant_count=5. A new job is then accepted normally.
- Busy protection and reset mid-job: while in GRANT, pulse req_valid with mask 0x1 → ignored and the sequence is unchanged. Then drop clear for one edge → all outputs 0 and state IDLE the next cycle.

Source files
------------

// File: rtl/bus_grant_sequencer.sv
// Sequences a 32-bit source mask into one-hot bus grants, highest bit first,
// one grant per consumer acknowledge, with a done pulse at the end of a job.
module bus_grant_sequencer #(
    parameter int unsigned N  = 32,
    parameter int unsigned CW = 6
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [N-1:0]  req_mask,
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    input  logic          grant_ack,
    input  logic          flush,
    output logic          done,
    output logic          busy,
    output logic [CW-1:0] grant_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [N-1:0]    pending;
    logic [N-1:0]    pending_nxt;
    logic [N-1:0]    remaining;
    logic [N-1:0]    grant_nxt;
    logic            grant_valid_nxt;
    logic            done_nxt;
    logic            busy_nxt;
    logic [CW-1:0]   count_nxt;

    // One-hot of the highest set bit; the downstream encoder gives bit N-1 priority.
    function automatic logic [N-1:0] top_bit(input logic [N-1:0] v);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    assign req_ready = clear && (state == IDLE);
    assign remaining = pending & ~grant;

    always_ff @(posedge clock) begin
        if (!clear) begin
            state       <= IDLE;
            pending     <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            grant_count <= '0;
        end else begin
            state       <= state_nxt;
            pending     <= pending_nxt;
            grant       <= grant_nxt;
            grant_valid <= grant_valid_nxt;
            done        <= done_nxt;
            busy        <= busy_nxt;
            grant_count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pending_nxt     = pending;
        grant_nxt       = grant;
        grant_valid_nxt = grant_valid;
        done_nxt        = 1'b0;
        count_nxt       = grant_count;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    pending_nxt = req_mask;
                    count_nxt   = '0;
                    if (req_mask != '0) begin
                        grant_nxt       = top_bit(req_mask);
                        grant_valid_nxt = 1'b1;
                        state_nxt       = GRANT;
                    end else begin
                        grant_nxt       = '0;
                        grant_valid_nxt = 1'b0;
                        done_nxt        = 1'b1;
                        state_nxt       = DONE;
                    end
                end
            end
            GRANT: begin
                // Flush takes priority over a same-cycle ack, which is then not counted.
                if (flush) begin
                    pending_nxt     = '0;
                    grant_nxt       = '0;
                    grant_valid_nxt = 1'b0;
                    state_nxt       = IDLE;
                end else if (grant_ack) begin
                    pending_nxt = remaining;
                    count_nxt   = grant_count + CW'(1);
                    if (remaining != '0) begin
                        grant_nxt = top_bit(remaining);
                    end else begin
                        grant_nxt       = '0;
                        grant_valid_nxt = 1'b0;
                        done_nxt        = 1'b1;
                        state_nxt       = DONE;
                    end
                end
            end
            DONE: begin
                pending_nxt     = '0;
                grant_nxt       = '0;
                grant_valid_nxt = 1'b0;
                state_nxt       = IDLE;
            end
            default: begin
                pending_nxt     = '0;
                grant_nxt       = '0;
                grant_valid_nxt = 1'b0;
                state_nxt       = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // Structural invariants of the grant bus.
    always_ff @(posedge clock) begin
        if (clear) begin
            assert ($onehot0(grant));
            assert (grant_valid == (grant != '0));
            assert (grant_count <= CW'(N));
        end
    end

endmodule

// File: tb/tb_bus_grant_sequencer.sv
// Directed and randomized bench for bus_grant_sequencer against a queue-based
// model of the job: remaining source indices in descending priority order.
module tb_bus_grant_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_mask;
    logic [31:0] grant;
    logic        grant_valid;
    logic        grant_ack;
    logic        flush;
    logic        done;
    logic        busy;
    logic [5:0]  grant_count;

    int checks = 0;
    int errors = 0;

    // Model: job phase, queue of indices still to grant (head = current grant).
    int m_phase = 0;   // 0 idle, 1 granting, 2 finished
    int m_q[$];
    int m_cnt = 0;

    bus_grant_sequencer dut (
        .clock       (clock),
        .clear       (clear),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_mask    (req_mask),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_ack   (grant_ack),
        .flush       (flush),
        .done        (done),
        .busy        (busy),
        .grant_count (grant_count)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_grant();
        logic [31:0] g;
        g = '0;
        if (m_phase == 1) g[m_q[0]] = 1'b1;
        return g;
    endfunction

    task automatic model_edge(input bit c, input bit rv, input logic [31:0] m,
                              input bit a, input bit f);
        if (!c) begin
            m_phase = 0;
            m_q.delete();
            m_cnt = 0;
        end else begin
            case (m_phase)
                0: if (rv) begin
                    m_q.delete();
                    for (int i = 31; i >= 0; i--) if (m[i]) m_q.push_back(i);
                    m_cnt   = 0;
                    m_phase = (m_q.size() != 0) ? 1 : 2;
                end
                1: if (f) begin
                    m_q.delete();
                    m_phase = 0;
                end else if (a) begin
                    void'(m_q.pop_front());
                    m_cnt++;
                    m_phase = (m_q.size() != 0) ? 1 : 2;
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    // Drive one cycle of inputs, check req_ready, clock it, then check all registered outputs.
    task automatic cyc(input bit c, input bit rv, input logic [31:0] m, input bit a, input bit f);
        clear     = c;
        req_valid = rv;
        req_mask  = m;
        grant_ack = a;
        flush     = f;
        #1;
        check_val("req_ready", 32'(req_ready), 32'(c && m_phase == 0));
        @(posedge clock);
        model_edge(c, rv, m, a, f);
        #1;
        check_val("grant", grant, exp_grant());
        check_val("grant_valid", 32'(grant_valid), 32'(m_phase == 1));
        check_val("done", 32'(done), 32'(m_phase == 2));
        check_val("busy", 32'(busy), 32'(m_phase != 0));
        check_val("grant_count", 32'(grant_count), 32'(m_cnt));
    endtask

    initial begin
        logic [31:0] rm;
        clear = 1'b0; req_valid = 1'b0; req_mask = '0; grant_ack = 1'b0; flush = 1'b0;
        @(posedge clock);
        #1;

        // Reset holds off a fully-offered job.
        cyc(0, 1, 32'hFFFF_FFFF, 0, 0);
        cyc(0, 1, 32'hFFFF_FFFF, 0, 0);
        check_val("rst_grant", grant, 32'h0);
        cyc(1, 0, 32'h0, 0, 0);
        check_val("rst_no_job", 32'(busy), 32'h0);

        // Continuous ack on a two-bit job.
        cyc(1, 1, 32'h8000_0001, 1, 0);
        check_val("cont_g1", grant, 32'h8000_0000);
        cyc(1, 0, 32'h0, 1, 0);
        check_val("cont_g2", grant, 32'h0000_0001);
        cyc(1, 0, 32'h0, 1, 0);
        check_val("cont_done", 32'(done), 32'h1);
        check_val("cont_count", 32'(grant_count), 32'd2);
        cyc(1, 0, 32'h0, 0, 0);

        // Stalled ack holds the grant.
        cyc(1, 1, 32'h0000_0050, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 32'h0, 0, 0);
            check_val("stall_hold", grant, 32'h0000_0040);
        end
        cyc(1, 0, 32'h0, 1, 0);
        check_val("stall_g2", grant, 32'h0000_0010);
        cyc(1, 0, 32'h0, 1, 0);
        check_val("stall_count", 32'(grant_count), 32'd2);
        cyc(1, 0, 32'h0, 0, 0);

        // Empty job: done right after accept, no grant.
        cyc(1, 1, 32'h0, 1, 0);
        check_val("empty_done", 32'(done), 32'h1);
        check_val("empty_count", 32'(grant_count), 32'd0);
        cyc(1, 0, 32'h0, 0, 0);

        // Flush wins over a same-cycle ack.
        cyc(1, 1, 32'hFFFF_FFFF, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 32'h0, 1, 0);
        check_val("flush_pre", grant, 32'h0400_0000);
        cyc(1, 0, 32'h0, 1, 1);
        check_val("flush_count", 32'(grant_count), 32'd5);
        check_val("flush_nodone", 32'(done), 32'h0);
        cyc(1, 1, 32'h0000_0300, 0, 1);
        check_val("flush_idle_accept", grant, 32'h0000_0200);

        // Request ignored while granting, then reset mid-job.
        cyc(1, 1, 32'h0000_0001, 0, 0);
        check_val("busy_ignore", grant, 32'h0000_0200);
        cyc(0, 0, 32'h0, 1, 0);
        check_val("midrst_grant", grant, 32'h0);
        cyc(1, 0, 32'h0, 0, 0);

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(0, 4))
                0:       rm = 32'h0;
                1:       rm = 32'hFFFF_FFFF;
                2:       rm = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
                default: rm = $urandom;
            endcase
            cyc(($urandom_range(0, 149) != 0), ($urandom_range(0, 2) == 0), rm,
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
